dcache_refill_unit: RTL

Miss handler directly downstream of the 4-way, 128-set, 64-byte-line data cache. It accepts one miss at a time from the cache's miss path and fetches the full 512-bit line from main memory as sixteen 32-bit beats. It chooses a victim way per set by round-robin, writes tag and line into the cache through a one-cycle refill strobe, then replays the original access to the load/store path.

---
 rtl/dcache_refill_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dcache_refill_unit.sv
// Line-refill miss handler for the 4-way, 128-set, 64-byte-line data cache.
// Fetches a line as sixteen 32-bit beats, installs it in a round-robin victim way, then replays the access.
module dcache_refill_unit #(
    parameter int LINE_BEATS = 16,
    parameter int NUM_SETS   = 128,
    parameter int NUM_WAYS   = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         miss_valid,
    output logic         miss_ready,
    input  logic [31:0]  miss_addr,
    input  logic [31:0]  miss_pc,
    input  logic         miss_is_store,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_req_addr,
    input  logic         mem_resp_valid,
    input  logic [31:0]  mem_resp_data,
    output logic         refill_valid,
    output logic [6:0]   refill_index,
    output logic [1:0]   refill_way,
    output logic [18:0]  refill_tag,
    output logic [511:0] refill_data,
    output logic         replay_valid,
    input  logic         replay_ready,
    output logic [31:0]  replay_pc,
    output logic [31:0]  replay_addr,
    output logic         replay_is_store,
    output logic         busy
);

    localparam int LINE_W = 32 * LINE_BEATS;
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        FILL   = 3'd2,
        WRITE  = 3'd3,
        REPLAY = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               beat_take_s;
    logic [31:0]        addr_r;
    logic [31:0]        pc_r;
    logic               store_r;
    logic [BEAT_W-1:0]  beat_r;
    logic [LINE_W-1:0]  line_r;
    logic [WAY_W-1:0]   rr_r [NUM_SETS];
    logic [6:0]         idx_s;

    assign idx_s = addr_r[12:6];

    // State register, miss context, beat assembly and per-set victim counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
            addr_r  <= 32'd0;
            pc_r    <= 32'd0;
            store_r <= 1'b0;
            beat_r  <= {BEAT_W{1'b0}};
            line_r  <= {LINE_W{1'b0}};
            for (int i = 0; i < NUM_SETS; i++) begin
                rr_r[i] <= {WAY_W{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r  <= miss_addr;
                pc_r    <= miss_pc;
                store_r <= miss_is_store;
                beat_r  <= {BEAT_W{1'b0}};
            end
            if (beat_take_s) begin
                line_r[{beat_r, 5'd0} +: 32] <= mem_resp_data;
                beat_r                       <= beat_r + BEAT_W'(1);
            end
            // The victim counter advances in the same cycle the refill strobe fires
            if (state_r == WRITE) begin
                rr_r[idx_s] <= rr_r[idx_s] + WAY_W'(1);
            end
        end
    end

    // Next-state decode; beats are only consumed in FILL so stray responses are dropped
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        beat_take_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (miss_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            FILL: begin
                if (mem_resp_valid) begin
                    beat_take_s = 1'b1;
                    if (beat_r == LAST_BEAT) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            WRITE: begin
                state_nxt_s = REPLAY;
            end
            REPLAY: begin
                if (replay_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REPLAY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign miss_ready      = (state_r == IDLE);
    assign busy            = (state_r != IDLE);
    assign mem_req_valid   = (state_r == REQ);
    assign mem_req_addr    = {addr_r[31:6], 6'd0};
    assign refill_valid    = (state_r == WRITE);
    assign refill_index    = idx_s;
    assign refill_way      = rr_r[idx_s];
    assign refill_tag      = addr_r[31:13];
    assign refill_data     = line_r;
    assign replay_valid    = (state_r == REPLAY);
    assign replay_pc       = pc_r;
    assign replay_addr     = addr_r;
    assign replay_is_store = store_r;

endmodule
